riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu.sv | 213 +++++++++++++++++++++
 tb/tb_riscv_lsu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one request at a time, word-wide memory bus,
// optional split of misaligned accesses into two beats, bus timeout abort.
module riscv_lsu #(
  parameter int ADDR_WIDTH       = 32,
  parameter int TIMEOUT          = 255,
  parameter bit SPLIT_MISALIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_error,
  output logic [1:0]            resp_cause,
  output logic                  mem_valid,
  output logic                  mem_instr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  localparam logic [1:0] C_OK = 2'd0, C_MIS = 2'd1, C_ILL = 2'd2, C_TMO = 2'd3;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  function automatic logic f3_illegal(input logic st, input logic [2:0] f3);
    return st ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd4:    return {24'd0, v[7:0]};
      3'd5:    return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic                  store_q, store_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic [1:0]            resp_cause_q, resp_cause_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [1:0]            off;
  logic [3:0]            size_mask;
  logic [7:0]            lane_mask;
  logic                  split, beat2, hs, stall, tmo_hit;
  logic [63:0]           wd_shift, rdata64;
  logic [31:0]           wd_rep, ld_word;
  logic [ADDR_WIDTH-3:0] word, word_nxt;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [3:0]            beat_strb;
  logic [31:0]           beat_wdata;

  // Byte-lane view over an 8-byte window: low nibble is the first word, high
  // nibble spills into the next word and is only non-zero for split accesses.
  always_comb begin
    off = addr_q[1:0];
    case (f3_q[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask = {4'd0, size_mask} << off;
    split     = (lane_mask[7:4] != 4'd0);
    beat2     = (state_q == ACC2);
    word      = addr_q[ADDR_WIDTH-1:2];
    word_nxt  = word + (ADDR_WIDTH-2)'(1);
    beat_addr = beat2 ? {word_nxt, 2'b00} : {word, 2'b00};
    wd_shift  = {32'd0, wdata_q} << {off, 3'b000};
    case (f3_q[1:0])
      2'd0:    wd_rep = {4{wdata_q[7:0]}};
      2'd1:    wd_rep = {2{wdata_q[15:0]}};
      default: wd_rep = wdata_q;
    endcase
    beat_strb  = 4'd0;
    beat_wdata = 32'd0;
    if (store_q) begin
      beat_strb  = beat2 ? lane_mask[7:4] : lane_mask[3:0];
      beat_wdata = split ? (beat2 ? wd_shift[63:32] : wd_shift[31:0]) : wd_rep;
    end
    rdata64 = beat2 ? {mem_rdata, lo_q} : {32'd0, mem_rdata};
    ld_word = rdata64[{off, 3'b000} +: 32];
    hs      = mem_valid_q && mem_ready;
    stall   = mem_valid_q && !mem_ready;
    tmo_hit = (TIMEOUT != 0) && stall && (cnt_q == TMO_LAST);
  end

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    resp_data_d  = resp_data_q;
    resp_cause_d = resp_cause_q;
    mem_valid_d  = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = 32'd0;
    mem_wstrb_d  = 4'd0;
    cnt_d        = stall ? cnt_q + CW'(1) : '0;
    case (state_q)
      IDLE: if (req_valid) begin
        store_d      = req_store;
        f3_d         = req_funct3;
        addr_d       = req_addr;
        wdata_d      = req_wdata;
        resp_data_d  = 32'd0;
        resp_cause_d = C_OK;
        if (f3_illegal(req_store, req_funct3)) begin
          resp_cause_d = C_ILL;
          state_d      = RESP;
        end else if (!SPLIT_MISALIGNED && f3_misaligned(req_funct3, req_addr[1:0])) begin
          resp_cause_d = C_MIS;
          state_d      = RESP;
        end else begin
          state_d = ACC1;
        end
      end
      ACC1, ACC2: begin
        // mem_valid is registered, so the first cycle of each beat only launches it.
        if (hs) begin
          if (!beat2 && split) begin
            lo_d    = mem_rdata;
            state_d = ACC2;
          end else begin
            resp_data_d = store_q ? 32'd0 : load_ext(f3_q, ld_word);
            state_d     = RESP;
          end
        end else if (tmo_hit) begin
          resp_cause_d = C_TMO;
          state_d      = RESP;
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = beat_addr;
          mem_wstrb_d = beat_strb;
          mem_wdata_d = beat_wdata;
        end
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      lo_q         <= 32'd0;
      resp_data_q  <= 32'd0;
      resp_cause_q <= C_OK;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      mem_wstrb_q  <= 4'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      resp_data_q  <= resp_data_d;
      resp_cause_q <= resp_cause_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_cause = resp_cause_q;
  assign resp_error = (resp_cause_q != C_OK);
  assign mem_valid  = mem_valid_q;
  assign mem_instr  = 1'b0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench: u0 rejects misaligned accesses, u1 splits them; both share
// stimulus and use TIMEOUT=4.
module tb_riscv_lsu;

  logic        clk, reset;
  logic        req_valid, req_store, resp_ready, mem_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;

  logic        r0_ready, v0, e0, mv0, mi0;
  logic [31:0] d0, ma0, mw0;
  logic [1:0]  c0;
  logic [3:0]  ms0;
  logic        r1_ready, v1, e1, mv1, mi1;
  logic [31:0] d1, ma1, mw1;
  logic [1:0]  c1;
  logic [3:0]  ms1;

  int checks = 0;
  int failures = 0;

  riscv_lsu #(.ADDR_WIDTH(32), .TIMEOUT(4), .SPLIT_MISALIGNED(1'b0)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r0_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(v0), .resp_ready(resp_ready),
    .resp_data(d0), .resp_error(e0), .resp_cause(c0), .mem_valid(mv0),
    .mem_instr(mi0), .mem_addr(ma0), .mem_wdata(mw0), .mem_wstrb(ms0),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata));

  riscv_lsu #(.ADDR_WIDTH(32), .TIMEOUT(4), .SPLIT_MISALIGNED(1'b1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r1_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(v1), .resp_ready(resp_ready),
    .resp_data(d1), .resp_error(e1), .resp_cause(c1), .mem_valid(mv1),
    .mem_instr(mi1), .mem_addr(ma1), .mem_wdata(mw1), .mem_wstrb(ms1),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    step(); step();
    check("rst_mem_valid", 32'(mv0), 32'd0);
    check("rst_wstrb", 32'(ms0), 32'd0);
    check("rst_addr", ma0, 32'd0);
    check("rst_wdata", mw0, 32'd0);
    check("rst_resp_valid", 32'(v0), 32'd0);
    check("rst_resp_data", d0, 32'd0);
    check("rst_cause", 32'(c0), 32'd0);
    check("rst_req_ready", 32'(r0_ready), 32'd1);
    reset = 1'b1;
    step();

    // LB at 0x103: sign-extended top byte
    mem_ready = 1'b1; mem_rdata = 32'h80FF_1122;
    issue(1'b0, 3'd0, 32'h103, 32'd0);
    check("lb_req_ready_busy", 32'(r0_ready), 32'd0);
    check("lb_mv_launch", 32'(mv0), 32'd0);
    step();
    check("lb_mem_valid", 32'(mv0), 32'd1);
    check("lb_mem_addr", ma0, 32'h100);
    check("lb_wstrb", 32'(ms0), 32'd0);
    check("lb_mem_instr", 32'(mi0), 32'd0);
    check("lb_resp_early", 32'(v0), 32'd0);
    step();
    check("lb_mv_drop", 32'(mv0), 32'd0);
    check("lb_resp_valid", 32'(v0), 32'd1);
    check("lb_resp_data", d0, 32'hFFFF_FF80);
    check("lb_cause", 32'(c0), 32'd0);
    check("lb_error", 32'(e0), 32'd0);
    step();
    check("lb_resp_hold", 32'(v0), 32'd1);
    check("lb_data_hold", d0, 32'hFFFF_FF80);
    release_resp();
    check("lb_resp_done", 32'(v0), 32'd0);
    check("lb_idle", 32'(r0_ready), 32'd1);

    // LHU at 0x102: zero-extended upper half
    issue(1'b0, 3'd5, 32'h102, 32'd0);
    step(); step();
    check("lhu_data", d0, 32'h0000_80FF);
    release_resp();

    // SH at 0x202
    issue(1'b1, 3'd1, 32'h202, 32'h0000_BEEF);
    step();
    check("sh_addr", ma0, 32'h200);
    check("sh_wstrb", 32'(ms0), 32'hC);
    check("sh_wdata", mw0, 32'hBEEF_BEEF);
    step();
    check("sh_resp_valid", 32'(v0), 32'd1);
    check("sh_resp_data", d0, 32'd0);
    check("sh_error", 32'(e0), 32'd0);
    release_resp();

    // LW at 0x301: u0 rejects, u1 splits into 0x300 / 0x304
    mem_ready = 1'b0;
    issue(1'b0, 3'd2, 32'h301, 32'd0);
    check("lwm_u0_resp", 32'(v0), 32'd1);
    check("lwm_u0_cause", 32'(c0), 32'd1);
    check("lwm_u0_error", 32'(e0), 32'd1);
    check("lwm_u0_data", d0, 32'd0);
    step();
    check("lwm_u0_no_bus", 32'(mv0), 32'd0);
    check("lws_b1_valid", 32'(mv1), 32'd1);
    check("lws_b1_addr", ma1, 32'h300);
    check("lws_b1_wstrb", 32'(ms1), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h4433_2211;
    step();
    check("lws_gap", 32'(mv1), 32'd0);
    check("lws_no_resp", 32'(v1), 32'd0);
    mem_rdata = 32'h8877_6655;
    step();
    check("lws_b2_valid", 32'(mv1), 32'd1);
    check("lws_b2_addr", ma1, 32'h304);
    step();
    check("lws_resp_valid", 32'(v1), 32'd1);
    check("lws_resp_data", d1, 32'h5544_3322);
    check("lws_cause", 32'(c1), 32'd0);
    check("lwm_u0_hold", 32'(c0), 32'd1);
    release_resp();
    check("lws_done", 32'(v1), 32'd0);

    // SW at 0x13 split on u1
    issue(1'b1, 3'd2, 32'h13, 32'hAABB_CCDD);
    step();
    check("sws_b1_addr", ma1, 32'h10);
    check("sws_b1_wstrb", 32'(ms1), 32'h8);
    check("sws_b1_wdata", mw1, 32'hDD00_0000);
    step(); step();
    check("sws_b2_addr", ma1, 32'h14);
    check("sws_b2_wstrb", 32'(ms1), 32'h7);
    check("sws_b2_wdata", mw1, 32'h00AA_BBCC);
    step();
    check("sws_resp", 32'(v1), 32'd1);
    check("sws_u0_cause", 32'(c0), 32'd1);
    release_resp();

    // SW at 0x10, memory never ready: four stalled cycles then abort
    mem_ready = 1'b0;
    issue(1'b1, 3'd2, 32'h10, 32'h1234_5678);
    step();
    check("tmo_valid0", 32'(mv0), 32'd1);
    check("tmo_addr", ma0, 32'h10);
    check("tmo_wstrb", 32'(ms0), 32'hF);
    check("tmo_wdata", mw0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      step();
      check("tmo_valid_hold", 32'(mv0), 32'd1);
    end
    step();
    check("tmo_drop", 32'(mv0), 32'd0);
    check("tmo_resp", 32'(v0), 32'd1);
    check("tmo_cause", 32'(c0), 32'd3);
    check("tmo_error", 32'(e0), 32'd1);
    check("tmo_u1_cause", 32'(c1), 32'd3);
    release_resp();

    // Load with funct3=3: immediate illegal response
    issue(1'b0, 3'd3, 32'h20, 32'd0);
    check("ill_resp", 32'(v0), 32'd1);
    check("ill_cause", 32'(c0), 32'd2);
    check("ill_error", 32'(e0), 32'd1);
    step();
    check("ill_no_bus", 32'(mv0), 32'd0);
    release_resp();

    // Reset while ACC1 is on the bus
    issue(1'b0, 3'd2, 32'h40, 32'd0);
    step();
    check("rstm_valid", 32'(mv0), 32'd1);
    reset = 1'b0;
    step();
    check("rstm_drop", 32'(mv0), 32'd0);
    check("rstm_no_resp", 32'(v0), 32'd0);
    reset = 1'b1;
    step(); step();
    check("rstm_still_no_resp", 32'(v0), 32'd0);
    check("rstm_idle", 32'(r0_ready), 32'd1);
    check("rstm_bus_idle", 32'(mv0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
